serial_add_sched: RTL and testbench
===================================

Name: serial_add_sched

Overview:
- Bit-serial addition engine that time-shares one 1-bit full-adder slice (sum = a ^ b ^ ci; carry = majority(a,b,ci)) between two requesters.
- Round-robin arbitration picks a requester and captures its operands. The block then sequences the slice LSB-first over WIDTH cycles and returns a WIDTH-bit result plus carry-out.
- Sits above the adder cell level; replaces WIDTH parallel adder instances where area matters more than latency.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req0  input  1  requester 0 request; held high with a0/b0 stable until gnt[0] seen.
- a0  input  WIDTH  requester 0 operand A.
- b0  input  WIDTH  requester 0 operand B.
- req1  input  1  requester 1 request; same rules as req0.
- a1  input  WIDTH  requester 1 operand A.
- b1  input  WIDTH  requester 1 operand B.
- gnt  output  2  one-hot grant pulse, 1 cycle; bit i = requester i's operands captured.
- busy  output  1  high while an addition is in progress (RUN or DONE).
- done  output  1  1-cycle pulse; result/cout/done_id valid.
- done_id  output  1  requester served by the current/last result.
- result  output  WIDTH  sum of captured operands mod 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.

Behaviour:
- Clock and reset: one clock (clk). Reset rst_n is asynchronous, active-low. While rst_n=0, all state is cleared:
  - state=IDLE;
  - gnt=0, busy=0, done=0, done_id=0, result=0, cout=0;
  - internal shift regs, carry and bit counter all 0;
  - round-robin pointer last=1, so requester 0 wins the first tie.
- Reset mid-operation aborts the addition. No done pulse is produced, and result/cout return to 0.
- FSM states: IDLE, RUN, DONE.
- IDLE, at an edge with any req high:
  - choose winner: single request -> that one; both -> requester != last;
  - capture winner's a/b into shift regs, carry=0, count=0;
  - last<=winner, done_id<=winner;
  - gnt[winner]=1 for the next cycle; busy=1; state goes to RUN.
- IDLE with no request: stay in IDLE, outputs hold.
- RUN, each edge:
  - bit = sa[0]^sb[0]^carry; carry <= majority(sa[0],sb[0],carry);
  - sa/sb shift right; bit shifts into the MSB of the result shift reg; count++;
  - when count reaches WIDTH-1 at this edge (i.e. the WIDTH-th bit), go to DONE.
  - RUN lasts exactly WIDTH cycles.
- Entering DONE: result <= completed shift reg; cout <= final carry.
- DONE: done=1 and busy=1 for exactly 1 cycle, then IDLE. busy=0 in IDLE.
- Timing: req sampled at edge E0; gnt high in cycle E0..E1; done high in cycle E(WIDTH+1)..E(WIDTH+2). Latency from capture edge to done = WIDTH+1 cycles.
- Throughput: the next capture occurs at the earliest edge E(WIDTH+3). One addition per WIDTH+3 cycles under continuous requests.
- Requests and operand changes during RUN/DONE are ignored; the captured values are used.
- A req still high in IDLE after its own done is treated as a new request.
- Held outputs: result, cout and done_id hold their values until the next DONE (or reset). done_id updates at capture.
- Arithmetic: unsigned modulo 2^WIDTH; cout is the true carry of the WIDTH-bit sum.
- WIDTH=1: RUN is a single cycle. Same behaviour otherwise.

Test Plan:
- WIDTH=8. req0 with a0=0x35, b0=0x4A -> gnt=01 one cycle after capture; done after 9 more cycles; result=0x7F, cout=0, done_id=0.
- req1 with a1=0xFF, b1=0x01 -> gnt=10; result=0x00, cout=1, done_id=1. Check wrap and carry-out.
- req0 and req1 both held high continuously from reset (operands 0x10+0x20 and 0x03+0x04) -> grants alternate 0,1,0,1. Results alternate 0x30/0x07. Consecutive captures spaced 11 cycles.
- After gnt, change a0/b0 to 0x00/0x00 during RUN -> result still reflects the captured operands 0xAA+0x55 = 0xFF, cout=0.
- Assert rst_n=0 for 1 cycle at RUN bit 4 -> all outputs 0 immediately, no done pulse. A new req0 0x01+0x01 afterwards -> result=0x02.
- WIDTH=1 build: req0 with a0=1, b0=1 -> done 2 cycles after capture; result=0, cout=1.

Source files
------------

// File: rtl/serial_add_sched.sv
// Bit-serial adder shared by two round-robin requesters: one full-adder slice
// walks the captured operands LSB-first and returns a WIDTH-bit sum plus carry.
module serial_add_sched #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   input  logic             req1,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   output logic [1:0]       gnt,
   output logic             busy,
   output logic             done,
   output logic             done_id,
   output logic [WIDTH-1:0] result,
   output logic             cout
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, nxt;
   logic [WIDTH-1:0] sa, sb, sr;
   logic             carry, last;
   logic [CW-1:0]    cnt;
   logic             go, win, bit_s, cry_s;
   logic [1:0]       gnt_c;
   logic             busy_c, done_c;

   // A request is not accepted while the done pulse is still on the outputs.
   assign go    = (req0 | req1) & ~done;
   assign win   = (req0 & req1) ? ~last : req1;
   assign bit_s = sa[0] ^ sb[0] ^ carry;
   assign cry_s = (sa[0] & sb[0]) | (sa[0] & carry) | (sb[0] & carry);

   // Next-state and registered-output decode.
   always_comb begin
      nxt    = state;
      gnt_c  = 2'b00;
      busy_c = 1'b0;
      done_c = 1'b0;
      case (state)
         IDLE: begin
            if (go) begin
               nxt    = RUN;
               gnt_c  = win ? 2'b10 : 2'b01;
               busy_c = 1'b1;
            end
         end
         RUN: begin
            busy_c = 1'b1;
            if (cnt == CW'(WIDTH - 1)) nxt = DONE;
         end
         DONE: begin
            busy_c = 1'b1;
            done_c = 1'b1;
            nxt    = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         gnt   <= 2'b00;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= nxt;
         gnt   <= gnt_c;
         busy  <= busy_c;
         done  <= done_c;
      end
   end

   // Operand capture, serial slice and result latch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sa      <= '0;
         sb      <= '0;
         sr      <= '0;
         carry   <= 1'b0;
         cnt     <= '0;
         last    <= 1'b1;
         done_id <= 1'b0;
         result  <= '0;
         cout    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (go) begin
                  sa      <= win ? a1 : a0;
                  sb      <= win ? b1 : b0;
                  sr      <= '0;
                  carry   <= 1'b0;
                  cnt     <= '0;
                  last    <= win;
                  done_id <= win;
               end
            end
            RUN: begin
               sa    <= sa >> 1;
               sb    <= sb >> 1;
               sr    <= (sr >> 1) | (WIDTH'(bit_s) << (WIDTH - 1));
               carry <= cry_s;
               cnt   <= cnt + CW'(1);
            end
            DONE: begin
               result <= sr;
               cout   <= carry;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_add_sched.sv
// Scoreboard bench for serial_add_sched: an 8-bit instance for arbitration,
// timing and reset abort, plus a 1-bit instance for the degenerate width.
module tb_serial_add_sched;

   typedef struct packed {
      logic       id;
      logic [7:0] res;
      logic       cy;
   } exp_t;

   logic       clk, rst_n;
   logic       req0, req1;
   logic [7:0] a0, b0, a1, b1;
   logic [1:0] gnt;
   logic       busy, done, done_id, cout;
   logic [7:0] result;

   logic       w_req0, w_req1, w_a0, w_b0, w_a1, w_b1;
   logic [1:0] w_gnt;
   logic       w_busy, w_done, w_done_id, w_result, w_cout;

   exp_t sbq[$];
   int   n_chk, n_fail;

   serial_add_sched #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .a0(a0), .b0(b0),
      .req1(req1), .a1(a1), .b1(b1),
      .gnt(gnt), .busy(busy), .done(done), .done_id(done_id),
      .result(result), .cout(cout)
   );

   serial_add_sched #(.WIDTH(1)) dut_w1 (
      .clk(clk), .rst_n(rst_n),
      .req0(w_req0), .a0(w_a0), .b0(w_b0),
      .req1(w_req1), .a1(w_a1), .b1(w_b1),
      .gnt(w_gnt), .busy(w_busy), .done(w_done), .done_id(w_done_id),
      .result(w_result), .cout(w_cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic exp_t model(input logic id, input logic [7:0] a, input logic [7:0] b);
      logic [8:0] s;
      exp_t e;
      s     = {1'b0, a} + {1'b0, b};
      e.id  = id;
      e.res = s[7:0];
      e.cy  = s[8];
      return e;
   endfunction

   // Compare every completion against the oldest expected transaction.
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (sbq.size() == 0) begin
            check("spurious_done", 32'(done), 32'd0);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            check("result", 32'(result), 32'(e.res));
            check("cout", 32'(cout), 32'(e.cy));
            check("done_id", 32'(done_id), 32'(e.id));
            check("busy_at_done", 32'(busy), 32'd1);
         end
      end
   end

   task automatic do_req(input logic id, input logic [7:0] a, input logic [7:0] b, input bit zap);
      int n;
      @(negedge clk);
      if (id) begin req1 = 1'b1; a1 = a; b1 = b; end
      else    begin req0 = 1'b1; a0 = a; b0 = b; end
      sbq.push_back(model(id, a, b));
      n = 0;
      do begin @(negedge clk); n++; end while (gnt == 2'b00 && n < 20);
      check("gnt", 32'(gnt), id ? 32'd2 : 32'd1);
      check("gnt_latency", 32'(n), 32'd1);
      req0 = 1'b0;
      req1 = 1'b0;
      if (zap) begin a0 = 8'h00; b0 = 8'h00; a1 = 8'h00; b1 = 8'h00; end
      n = 0;
      while (!done && n < 30) begin @(negedge clk); n++; end
      check("done_latency", 32'(n), 32'd9);
      @(negedge clk);
      check("busy_idle", 32'(busy), 32'd0);
      check("done_pulse", 32'(done), 32'd0);
   endtask

   initial begin
      int n;
      n_chk  = 0;
      n_fail = 0;
      w_req0 = 1'b0; w_req1 = 1'b0;
      w_a0 = 1'b0; w_b0 = 1'b0; w_a1 = 1'b0; w_b1 = 1'b0;

      // Both requesters held from reset.
      rst_n = 1'b0;
      req0 = 1'b1; a0 = 8'h10; b0 = 8'h20;
      req1 = 1'b1; a1 = 8'h03; b1 = 8'h04;
      repeat (2) @(negedge clk);
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_cout", 32'(cout), 32'd0);
      check("rst_done_id", 32'(done_id), 32'd0);
      for (int k = 0; k < 4; k++) sbq.push_back(model(k[0], k[0] ? 8'h03 : 8'h10, k[0] ? 8'h04 : 8'h20));
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         n = 0;
         do begin @(negedge clk); n++; end while (gnt == 2'b00 && n < 30);
         check("alt_gnt", 32'(gnt), k[0] ? 32'd2 : 32'd1);
         check("alt_spacing", 32'(n), (k == 0) ? 32'd1 : 32'd11);
      end
      req0 = 1'b0;
      req1 = 1'b0;
      repeat (14) @(negedge clk);

      do_req(1'b0, 8'h35, 8'h4A, 1'b0);
      do_req(1'b1, 8'hFF, 8'h01, 1'b0);
      do_req(1'b0, 8'hAA, 8'h55, 1'b1);

      // Reset during RUN: no completion may follow.
      @(negedge clk);
      req0 = 1'b1; a0 = 8'h12; b0 = 8'h34;
      n = 0;
      do begin @(negedge clk); n++; end while (gnt == 2'b00 && n < 20);
      check("abort_gnt", 32'(gnt), 32'd1);
      req0 = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_result", 32'(result), 32'd0);
      check("abort_cout", 32'(cout), 32'd0);
      check("abort_gnt_clr", 32'(gnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      do_req(1'b0, 8'h01, 8'h01, 1'b0);

      // Single-bit instance.
      @(negedge clk);
      w_req0 = 1'b1; w_a0 = 1'b1; w_b0 = 1'b1;
      @(negedge clk);
      check("w1_gnt", 32'(w_gnt), 32'd1);
      w_req0 = 1'b0;
      n = 0;
      while (!w_done && n < 10) begin @(negedge clk); n++; end
      check("w1_latency", 32'(n), 32'd2);
      check("w1_result", 32'(w_result), 32'd0);
      check("w1_cout", 32'(w_cout), 32'd1);
      check("w1_done_id", 32'(w_done_id), 32'd0);

      n = 0;
      while (sbq.size() != 0 && n < 50) begin @(negedge clk); n++; end
      check("sb_empty", 32'(sbq.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
